// File: rtl/jogo_pkg.sv
// Shared definitions for the game blocks: default sizes and the
// encoding of the move-detector states (also exposed on db_estado).
package jogo_pkg;

  localparam int N_BOTOES_PADRAO        = 4;
  localparam int LARGURA_JOGADA_PADRAO  = 2;
  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

  localparam logic [2:0] COD_OCIOSO        = 3'd0;
  localparam logic [2:0] COD_ESPERA_BOTAO  = 3'd1;
  localparam logic [2:0] COD_FILTRA        = 3'd2;
  localparam logic [2:0] COD_EMITE         = 3'd3;
  localparam logic [2:0] COD_INVALIDA      = 3'd4;
  localparam logic [2:0] COD_ESPERA_SOLTAR = 3'd5;

  typedef enum logic [2:0] {
    OCIOSO        = COD_OCIOSO,
    ESPERA_BOTAO  = COD_ESPERA_BOTAO,
    FILTRA        = COD_FILTRA,
    EMITE         = COD_EMITE,
    INVALIDA      = COD_INVALIDA,
    ESPERA_SOLTAR = COD_ESPERA_SOLTAR
  } estado_t;

endpackage

// File: rtl/detector_de_jogada_if.sv
// Move handshake between the push-buttons / control unit and the move
// detector. The detector drives the master side.
interface detector_de_jogada_if
  import jogo_pkg::*;
#(
  parameter int N_BOTOES       = N_BOTOES_PADRAO,
  parameter int LARGURA_JOGADA = LARGURA_JOGADA_PADRAO
);

  logic                      habilita;
  logic [N_BOTOES-1:0]       botoes;
  logic                      fez_jogada;
  logic [LARGURA_JOGADA-1:0] jogada;
  logic                      jogada_invalida;
  logic [2:0]                db_estado;

  modport master (
    input  habilita, botoes,
    output fez_jogada, jogada, jogada_invalida, db_estado
  );

  modport slave (
    output habilita, botoes,
    input  fez_jogada, jogada, jogada_invalida, db_estado
  );

endinterface

// File: rtl/sincronizador_botoes.sv
// Two-flop synchronizer for the raw asynchronous push-buttons.
module sincronizador_botoes
  import jogo_pkg::*;
#(
  parameter int LARGURA = N_BOTOES_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] saida
);

  logic [LARGURA-1:0] estagio1_r;
  logic [LARGURA-1:0] estagio2_r;

  // Two-stage chain so the FSM never sees a metastable level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estagio1_r <= '0;
      estagio2_r <= '0;
    end else begin
      estagio1_r <= entrada;
      estagio2_r <= estagio1_r;
    end
  end

  assign saida = estagio2_r;

endmodule

// File: rtl/detector_de_jogada.sv
// Player-move detector: synchronizes and debounces the answer buttons,
// emits one fez_jogada pulse per accepted single-button press and one
// jogada_invalida pulse per multi-button press.
// Build option: DETECTOR_JOGADA_DEBOUNCE_EN builds the debounce counter;
// without it FILTRA and ESPERA_SOLTAR last a single cycle each.
module detector_de_jogada
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int LARGURA_JOGADA  = LARGURA_JOGADA_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input logic                  clock,
  input logic                  reset,
  detector_de_jogada_if.master bus
);

  if (LARGURA_JOGADA != $clog2(N_BOTOES)) begin : g_chk_largura
    $error("LARGURA_JOGADA must equal clog2(N_BOTOES)");
  end
  if (DEBOUNCE_CICLOS < 2) begin : g_chk_debounce
    $error("DEBOUNCE_CICLOS must be at least 2");
  end

  // True when exactly one button is pressed
  function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

  // Binary index of the set bit of a one-hot vector
  function automatic logic [LARGURA_JOGADA-1:0] indice_one_hot(input logic [N_BOTOES-1:0] v);
    logic [LARGURA_JOGADA-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (v[i]) begin
        idx = LARGURA_JOGADA'(i);
      end
    end
    return idx;
  endfunction

  logic [N_BOTOES-1:0]       sinc_s;
  logic                      padrao_one_hot_s;
  logic [LARGURA_JOGADA-1:0] padrao_indice_s;

  estado_t                   estado_r;
  logic [N_BOTOES-1:0]       padrao_r;
  logic [LARGURA_JOGADA-1:0] jogada_r;
  logic                      fez_jogada_r;
  logic                      jogada_invalida_r;

`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
  localparam int LARGURA_CONT = $clog2(DEBOUNCE_CICLOS);
  localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
  logic [LARGURA_CONT-1:0] contador_r;
`endif

  sincronizador_botoes #(.LARGURA(N_BOTOES)) u_sinc (
    .clock   (clock),
    .reset   (reset),
    .entrada (bus.botoes),
    .saida   (sinc_s)
  );

  assign padrao_one_hot_s = eh_one_hot(padrao_r);
  assign padrao_indice_s  = indice_one_hot(padrao_r);

  // Move FSM; pulses and jogada are registered on the edge entering EMITE/INVALIDA
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r          <= OCIOSO;
      padrao_r          <= '0;
      jogada_r          <= '0;
      fez_jogada_r      <= 1'b0;
      jogada_invalida_r <= 1'b0;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
      contador_r        <= '0;
`endif
    end else begin
      fez_jogada_r      <= 1'b0;
      jogada_invalida_r <= 1'b0;
      case (estado_r)
        OCIOSO: begin
          // go through ESPERA_SOLTAR so a button held from the last round is ignored
          if (bus.habilita) begin
            estado_r <= ESPERA_SOLTAR;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
            contador_r <= '0;
`endif
          end
        end
        ESPERA_BOTAO: begin
          if (!bus.habilita) begin
            estado_r <= OCIOSO;
          end else if (sinc_s != '0) begin
            padrao_r <= sinc_s;
            estado_r <= FILTRA;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
            contador_r <= '0;
`endif
          end
        end
        FILTRA: begin
          if (sinc_s != padrao_r) begin
            estado_r <= ESPERA_BOTAO;
          end else if (!bus.habilita) begin
            estado_r <= OCIOSO;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
          end else if (contador_r != CONT_MAX) begin
            contador_r <= contador_r + LARGURA_CONT'(1);
`endif
          end else if (padrao_one_hot_s) begin
            estado_r     <= EMITE;
            fez_jogada_r <= 1'b1;
            jogada_r     <= padrao_indice_s;
          end else begin
            estado_r          <= INVALIDA;
            jogada_invalida_r <= 1'b1;
          end
        end
        EMITE, INVALIDA: begin
          estado_r <= ESPERA_SOLTAR;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
          contador_r <= '0;
`endif
        end
        ESPERA_SOLTAR: begin
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
          // any pressed button restarts the release filter
          if (sinc_s != '0) begin
            contador_r <= '0;
          end else if (contador_r != CONT_MAX) begin
            contador_r <= contador_r + LARGURA_CONT'(1);
          end else begin
            estado_r <= bus.habilita ? ESPERA_BOTAO : OCIOSO;
          end
`else
          if (sinc_s == '0) begin
            estado_r <= bus.habilita ? ESPERA_BOTAO : OCIOSO;
          end
`endif
        end
        default: begin
          estado_r <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.fez_jogada      = fez_jogada_r;
  assign bus.jogada          = jogada_r;
  assign bus.jogada_invalida = jogada_invalida_r;
  assign bus.db_estado       = estado_r;

endmodule

// File: tb/tb_detector_de_jogada.sv
// Directed bench for detector_de_jogada. Expected pulses (kind, code and
// cycle) are queued by the stimulus; a monitor pops one per observed pulse.
// Timing expectations follow the build: with the debounce counter the
// filters last DB cycles, without it they last one cycle.
module tb_detector_de_jogada;

  localparam int NB = 4;
  localparam int LJ = 2;
  localparam int DB = 4;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
  localparam int EFF = DB;
`else
  localparam int EFF = 1;
`endif

  typedef struct {
    bit          invalida;
    logic [LJ-1:0] jogada;
    int          ciclo;
  } esperado_t;

  logic clock = 1'b0;
  logic reset;
  int   ciclo = 0;
  int   total = 0;
  int   bad = 0;
  esperado_t fila[$];
  esperado_t e_mon;

  detector_de_jogada_if #(.N_BOTOES(NB), .LARGURA_JOGADA(LJ)) bus ();

  detector_de_jogada #(
    .N_BOTOES(NB), .LARGURA_JOGADA(LJ), .DEBOUNCE_CICLOS(DB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // ciclo = number of rising edges seen so far
  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic checar(input string nome, input logic [31:0] atual, input logic [31:0] requerido);
    total++;
    if (atual !== requerido) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, atual, requerido, ciclo);
    end
  endtask

  task automatic ate(input int t);
    while (ciclo < t) @(negedge clock);
  endtask

  task automatic esperar_pulso(input bit inv, input logic [LJ-1:0] j, input int quando);
    esperado_t x;
    x.invalida = inv;
    x.jogada   = j;
    x.ciclo    = quando;
    fila.push_back(x);
  endtask

  // release the buttons and check the release filter re-arms on time
  task automatic soltar();
    int r;
    r = ciclo;
    bus.botoes = 4'b0000;
    ate(r + 1 + EFF);
    checar("rearm_wait", bus.db_estado, 3'd5);
    ate(r + 2 + EFF);
    checar("rearm", bus.db_estado, 3'd1);
  endtask

  // monitor: every pulse must match the head of the scoreboard
  always @(negedge clock) begin
    if (bus.fez_jogada === 1'b1 || bus.jogada_invalida === 1'b1) begin
      checar("exclusive", bus.fez_jogada & bus.jogada_invalida, 1'b0);
      if (fila.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got fez=%0b inv=%0b jogada=%0d expected none (cycle %0d)",
                 bus.fez_jogada, bus.jogada_invalida, bus.jogada, ciclo);
      end else begin
        e_mon = fila.pop_front();
        checar("pulse_kind", bus.jogada_invalida, e_mon.invalida);
        checar("pulse_jogada", bus.jogada, e_mon.jogada);
        checar("pulse_cycle", ciclo, e_mon.ciclo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0, d, b, t, h, p, f, g, q;
    reset = 1'b1;
    bus.habilita = 1'b0;
    bus.botoes = 4'b0000;
    ate(2);
    checar("reset_estado", bus.db_estado, 3'd0);
    checar("reset_fez", bus.fez_jogada, 1'b0);
    checar("reset_inv", bus.jogada_invalida, 1'b0);
    checar("reset_jogada", bus.jogada, 2'd0);
    reset = 1'b0;

    // enable with buttons released: the sampling edge counts as the first of DB+1
    ate(4);
    bus.habilita = 1'b1;
    ate(5);
    checar("enable_soltar", bus.db_estado, 3'd5);
    ate(4 + EFF);
    checar("enable_soltar_end", bus.db_estado, 3'd5);
    ate(5 + EFF);
    checar("enable_botao", bus.db_estado, 3'd1);

    // clean single press: pulse after edge 0 + EFF + 2
    c0 = 5 + EFF + 2;
    ate(c0);
    bus.botoes = 4'b0100;
    esperar_pulso(1'b0, 2'd2, c0 + EFF + 3);
    ate(c0 + 3);
    checar("clean_filtra", bus.db_estado, 3'd2);
    ate(c0 + EFF + 3);
    checar("clean_emite", bus.db_estado, 3'd3);
    ate(c0 + EFF + 4);
    checar("clean_soltar", bus.db_estado, 3'd5);
    ate(c0 + 20);
    soltar();

    // two buttons: invalid pulse, jogada keeps 2
    d = ciclo + 2;
    ate(d);
    bus.botoes = 4'b0011;
    esperar_pulso(1'b1, 2'd2, d + EFF + 3);
    ate(d + EFF + 3);
    checar("invalid_state", bus.db_estado, 3'd4);
    ate(d + 12);
    soltar();
    checar("invalid_jogada_hold", bus.jogada, 2'd2);

    // bounce: 2 cycles on, 1 off, then stable
    b = ciclo + 2;
    ate(b);
    bus.botoes = 4'b0001;
    ate(b + 2);
    bus.botoes = 4'b0000;
    ate(b + 3);
    bus.botoes = 4'b0001;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
    esperar_pulso(1'b0, 2'd0, b + 6 + EFF);
`else
    esperar_pulso(1'b0, 2'd0, b + 3 + EFF);
`endif
    ate(b + 20);
    soltar();

    // button held while habilita rises: nothing until release and a new press
    t = ciclo + 1;
    ate(t);
    bus.habilita = 1'b0;
    ate(t + 1);
    checar("disable_ocioso", bus.db_estado, 3'd0);
    bus.botoes = 4'b0010;
    h = t + 6;
    ate(h);
    bus.habilita = 1'b1;
    ate(h + 1);
    checar("held_soltar", bus.db_estado, 3'd5);
    ate(h + 15);
    checar("held_still_soltar", bus.db_estado, 3'd5);
    soltar();
    p = ciclo + 1;
    ate(p);
    bus.botoes = 4'b0010;
    esperar_pulso(1'b0, 2'd1, p + EFF + 3);
    ate(p + 12);
    soltar();

    // habilita dropped in FILTRA: back to OCIOSO, no pulse
    f = ciclo + 1;
    ate(f);
    bus.botoes = 4'b1000;
    ate(f + 3);
    checar("drop_filtra", bus.db_estado, 3'd2);
    bus.habilita = 1'b0;
    ate(f + 4);
    checar("drop_ocioso", bus.db_estado, 3'd0);
    bus.botoes = 4'b0000;
    ate(f + 10);
    checar("drop_stays", bus.db_estado, 3'd0);

    // re-enable and press the highest button
    g = ciclo;
    bus.habilita = 1'b1;
    ate(g + 1 + EFF);
    checar("reenable_botao", bus.db_estado, 3'd1);
    p = g + EFF + 2;
    ate(p);
    bus.botoes = 4'b1000;
    esperar_pulso(1'b0, 2'd3, p + EFF + 3);
    ate(p + 12);
    soltar();

    // asynchronous reset while filtering: immediate OCIOSO, pulse lost
    q = ciclo + 1;
    ate(q);
    bus.botoes = 4'b0001;
    ate(q + 3);
    checar("prereset_filtra", bus.db_estado, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    checar("async_reset_estado", bus.db_estado, 3'd0);
    checar("async_reset_jogada", bus.jogada, 2'd0);
    bus.botoes = 4'b0000;
    bus.habilita = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    ate(ciclo + EFF + 10);
    checar("post_reset_estado", bus.db_estado, 3'd0);
    checar("scoreboard_empty", fila.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/detector_de_jogada.md
# detector_de_jogada

Produces the player-move handshake consumed by the game control unit. It synchronizes and debounces the answer buttons, and rejects presses of zero or several buttons. Each accepted press becomes a single-cycle `fez_jogada` pulse with a registered binary `jogada` code. The block sits between the board push-buttons and the control unit, and is enabled only while the control unit waits for a move.

## Interface
Parameters:
- `N_BOTOES`, default 4: number of answer buttons.
- `LARGURA_JOGADA`, default 2: width of `jogada`; must equal $clog2(N_BOTOES).
- `DEBOUNCE_CICLOS`, default 50000: stable cycles required before a level is trusted (1 ms at 50 MHz); minimum 2.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-high.
- `habilita` in 1: accept moves; driven by the control unit's wait-for-move state.
- `botoes` in N_BOTOES: raw asynchronous buttons, active-high.
- `fez_jogada` out 1: one-cycle pulse when a valid move is accepted.
- `jogada` out LARGURA_JOGADA: index of the pressed button; holds its value until the next accepted move.
- `jogada_invalida` out 1: one-cycle pulse when more than one button is stable-pressed.
- `db_estado` out 3: current state, for debug.

## Operation
- `botoes` passes through a 2-flop synchronizer, giving `sinc`. The FSM sees only `sinc`.
- States and encoding:
  - OCIOSO=0: if `habilita`, go to ESPERA_SOLTAR, so a button held from the previous round is never accepted.
  - ESPERA_BOTAO=1:
    - if `!habilita`, go to OCIOSO;
    - else if `sinc!=0`, latch `sinc` into `padrao`, clear the counter and go to FILTRA.
  - FILTRA=2: the counter increments every cycle.
    - if `sinc!=padrao`, go to ESPERA_BOTAO (the filter restarts);
    - else if `!habilita`, go to OCIOSO;
    - else if counter==DEBOUNCE_CICLOS-1: go to EMITE if `padrao` is one-hot, else go to INVALIDA.
  - EMITE=3: `fez_jogada`=1 and `jogada` is loaded with the one-hot index. Go to ESPERA_SOLTAR unconditionally.
  - INVALIDA=4: `jogada_invalida`=1 and `jogada` is unchanged. Go to ESPERA_SOLTAR unconditionally.
  - ESPERA_SOLTAR=5: the counter runs while `sinc==0` and clears whenever `sinc!=0`. When it reaches DEBOUNCE_CICLOS-1:
    - go to ESPERA_BOTAO if `habilita`;
    - go to OCIOSO otherwise.
  - Unused encodings go to OCIOSO.
- The counter saturates at DEBOUNCE_CICLOS-1 and is sized $clog2(DEBOUNCE_CICLOS).
- `fez_jogada` and `jogada_invalida` are Moore outputs and are never high in the same cycle.
- `habilita` falling during EMITE or INVALIDA does not suppress the pulse.

## Timing
- Reset values:
  - state OCIOSO, so `db_estado`=0;
  - `fez_jogada`=0, `jogada_invalida`=0, `jogada`=0;
  - counter 0, `padrao` 0, synchronizer flops 0.
- Edge numbering: let edge 0 be the first edge that samples a stable press while in ESPERA_BOTAO.
  - FILTRA is entered at edge 2.
  - EMITE is entered at edge DEBOUNCE_CICLOS+2, and `fez_jogada` is high for exactly the following cycle.
- Accept-to-rearm time: a release is honoured DEBOUNCE_CICLOS+2 edges after it is first sampled.
- Enable latency: after `habilita` rises from OCIOSO with buttons released, ESPERA_BOTAO is reached DEBOUNCE_CICLOS+1 edges later.
- A bounce shorter than DEBOUNCE_CICLOS cycles never produces a pulse.
- Asserting `reset` mid-operation returns the block to OCIOSO immediately; any pulse in flight is lost.

## Configuration
- `DETECTOR_JOGADA_DEBOUNCE_EN` defined: behaviour exactly as above.
- Undefined: the debounce counter is not built.
  - FILTRA and ESPERA_SOLTAR each last exactly one cycle, as if DEBOUNCE_CICLOS=1.
  - FILTRA still returns to ESPERA_BOTAO if `sinc!=padrao`.
  - ESPERA_SOLTAR waits for `sinc==0`.
  - `fez_jogada` rises at edge 3.
  - Used for simulation speed and for boards with hardware-debounced buttons.

## Structure
- Shared package `jogo_pkg`: the state encoding localparams (OCIOSO..ESPERA_SOLTAR) and the default N_BOTOES, DEBOUNCE_CICLOS and LARGURA_JOGADA.
- One sub-module, `sincronizador_botoes`: a parameterized-width 2-flop synchronizer with asynchronous active-high reset.
- One-hot check and encoder: combinational logic inside `detector_de_jogada`.

## Test plan
All scenarios use DEBOUNCE_CICLOS=4 with the macro defined, unless noted.
- Reset, then `habilita`=1 with buttons released → `db_estado` goes 0→5, then reaches 1 five edges after `habilita` is sampled; outputs stay 0.
- Clean press `botoes`=4'b0100 held for 20 cycles → `fez_jogada` high for exactly one cycle after edge 6 and `jogada`=2. No further pulse until the button is released and re-pressed.
- Bounce: 4'b0001 for 2 cycles, 0 for 1 cycle, then stable → the filter restarts, one pulse results with `jogada`=0, and the pulse arrives later than in the clean case.
- `botoes`=4'b0011 held → `jogada_invalida` is a single one-cycle pulse, `fez_jogada` stays 0, and `jogada` keeps its previous value.
- Button held while `habilita` rises → no pulse until release plus a new press. Dropping `habilita` in FILTRA → OCIOSO with no pulse.
- Macro undefined, press 4'b1000 → `fez_jogada` after edge 3 and `jogada`=3. Asynchronous reset in FILTRA → `db_estado`=0 immediately.
